// File: rtl/ack_done_sequencer.sv
// Job handshake generator: accepts a request, acks it, holds enable across the
// job window and reports completion (done) or a stall abort (done + err).
module ack_done_sequencer #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [LEN_W-1:0] len,
    input  logic             beat,
    output logic             ack,
    output logic             enable,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [TO_W-1:0]  STALL_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    stall_q, stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    len_d   = (len == '0) ? LEN_ONE : len;
                    cnt_d   = '0;
                    stall_d = '0;
                    state_d = S_ACK;
                end
            end
            S_ACK: state_d = S_RUN;
            S_RUN: begin
                // A beat always wins over a simultaneous stall expiry.
                if (beat) begin
                    cnt_d   = cnt_q + LEN_ONE;
                    stall_d = '0;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end else begin
                    stall_d = stall_q + TO_W'(1);
                    if (stall_q == STALL_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack      = (state_q == S_ACK);
        done     = (state_q == S_DONE) || (state_q == S_ERR);
        err      = (state_q == S_ERR);
        busy     = (state_q != S_IDLE);
        enable   = busy;
        beat_cnt = cnt_q;
    end

endmodule

// File: tb/tb_ack_done_sequencer.sv
// Directed and random job traffic; expectations come from a per-job predictor
// that derives the run length from the beat pattern and the length/timeout rules.
module tb_ack_done_sequencer;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             beat = 1'b0;
    logic             ack, enable, done, err, busy;
    logic [LEN_W-1:0] beat_cnt;

    int errors = 0;
    int checks = 0;
    int cycles = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    ack_done_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .beat(beat),
        .ack(ack), .enable(enable), .done(done), .err(err), .busy(busy),
        .beat_cnt(beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycles);
        end
    endtask

    task automatic chk_outs(input string tag, input bit e_ack, input bit e_en, input bit e_done,
                            input bit e_err, input bit e_busy, input int e_cnt);
        chk({tag, ".ack"},      32'(ack),      32'(e_ack));
        chk({tag, ".enable"},   32'(enable),   32'(e_en));
        chk({tag, ".done"},     32'(done),     32'(e_done));
        chk({tag, ".err"},      32'(err),      32'(e_err));
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(e_cnt));
    endtask

    // One clock cycle: check the outputs visible in this cycle, then drive inputs for the next edge.
    task automatic cyc(input string tag, input bit e_ack, input bit e_en, input bit e_done,
                       input bit e_err, input bit e_busy, input int e_cnt,
                       input bit i_req, input int i_len, input bit i_beat);
        @(negedge clk);
        cycles++;
        chk_outs(tag, e_ack, e_en, e_done, e_err, e_busy, e_cnt);
        req  = i_req;
        len  = LEN_W'(i_len);
        beat = i_beat;
    endtask

    // One complete job: gap idle cycles (req raised on the last), ack, RUN until the
    // len-th beat or TIMEOUT consecutive empty cycles, then the done/err cycle.
    task automatic job(input string tag, input int lenv, input int gap, input bit hold_next,
                       input bit use_mask, input logic [31:0] mask, input int pct);
        int  target = (lenv == 0) ? 1 : lenv;
        int  cnt = 0;
        int  stalls = 0;
        int  j = 0;
        bit  fin = 0;
        bit  to = 0;
        bit  b;
        for (int i = 0; i < gap; i++) begin
            cyc({tag, ".idle"}, 0, 0, 0, 0, 0, last_cnt, (i == gap - 1),
                (i == gap - 1) ? lenv : int'($urandom_range(255)), 1'($urandom));
        end
        cyc({tag, ".ack"}, 1, 1, 0, 0, 1, 0, 1'($urandom), int'($urandom_range(255)), 1'($urandom));
        while (!fin) begin
            j++;
            if (use_mask) b = (j <= 32) ? mask[j-1] : 1'b0;
            else          b = (int'($urandom_range(99)) < pct);
            cyc({tag, ".run"}, 0, 1, 0, 0, 1, cnt, 1'($urandom), int'($urandom_range(255)), b);
            if (b) begin
                cnt++;
                stalls = 0;
                if (cnt == target) fin = 1;
            end else begin
                stalls++;
                if (stalls == TIMEOUT) begin
                    fin = 1;
                    to  = 1;
                end
            end
        end
        cyc({tag, ".done"}, 0, 1, 1, to, 1, cnt, hold_next, int'($urandom_range(255)), 1'($urandom));
        $display("job %s len=%0d beats=%0d run_cycles=%0d timeout=%0d", tag, lenv, cnt, j, to);
        last_cnt = cnt;
    endtask

    initial begin
        int pcts[4] = '{100, 70, 30, 3};

        // Reset state, including a clock edge while held.
        #2;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_outs("reset_hold", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        job("nominal",  3, 1, 0, 1, 32'hFFFF_FFFF, 0);
        job("stalled",  2, 2, 0, 1, 32'h0000_0009, 0);
        job("timeout",  4, 1, 0, 1, 32'h0000_0001, 0);
        job("len0",     0, 1, 1, 1, 32'h0000_0001, 0);
        job("b2b",      2, 1, 0, 1, 32'hFFFF_FFFF, 0);
        job("len_max", 255, 1, 0, 0, 32'h0, 100);

        // Reset in the middle of a RUN with two beats counted.
        cyc("mid.idle", 0, 0, 0, 0, 0, last_cnt, 1, 5, 0);
        cyc("mid.ack",  1, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc("mid.run0", 0, 1, 0, 0, 1, 0, 0, 0, 1);
        cyc("mid.run1", 0, 1, 0, 0, 1, 1, 0, 0, 1);
        @(negedge clk);
        chk_outs("mid.run2", 0, 1, 0, 0, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("mid.async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_outs("mid.rst_held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        last_cnt = 0;
        $display("job mid_reset aborted by reset at beat_cnt=2");
        job("after_rst", 1, 1, 0, 1, 32'h0000_0001, 0);

        // Random traffic.
        cycles = 0;
        for (int n = 0; cycles < 1000; n++) begin
            job($sformatf("rnd%0d", n), int'($urandom_range(12)), int'($urandom_range(3)) + 1,
                1'($urandom), 0, 32'h0, pcts[$urandom_range(3)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
